// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and the opcode decoder:
// opcode constants, the NOP word and the fetch state encoding.
package fetch_stage_pkg;

    localparam logic [4:0]  OP_HALT  = 5'b00000;
    localparam logic [4:0]  OP_NOP   = 5'b00001;
    localparam logic [15:0] NOP_WORD = {OP_NOP, 11'b0};

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HALTED = 2'd1,
        ST_ERR    = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [15:0] w);
        return w[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program counter with async reset to RESET_PC, a load port
// and a step-by-2 enable.
// Ports: clk, rst, i_load, i_load_pc, i_inc -> o_pc, o_pc_plus2.
module pc_reg #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_pc,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_plus2
);

    localparam logic [PC_W-1:0] TWO = {{(PC_W-2){1'b0}}, 2'b10};

    logic [PC_W-1:0] r_pc;

    // Load wins over increment; both wrap modulo 2^PC_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= o_pc_plus2;
        end
    end

    assign o_pc       = r_pc;
    assign o_pc_plus2 = r_pc + TWO;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with ready handshake, HALT stop and
// execute-stage redirects. Optional macro ALIGN_CHECK_EN enables the
// misaligned-redirect error state.
// Ports: clk, rst, imem_req/addr/rdata/ready, redirect_valid/pc,
// stall_in, instr_out, instr_valid, pc_out, pc_plus2_out, halted, err.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            stall_in,
    output logic [15:0]     instr_out,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus2_out,
    output logic            halted,
    output logic            err
);

    localparam logic [PC_W-1:0] TWO = {{(PC_W-2){1'b0}}, 2'b10};
    localparam logic [PC_W-1:0] RESET_PC2 = RESET_PC + TWO;

    fetch_state_e    r_state;
    logic [15:0]     r_instr;
    logic            r_valid;
    logic [PC_W-1:0] r_pc_out;
    logic [PC_W-1:0] r_pc_plus2;
    logic            r_halted;

    logic [PC_W-1:0] w_pc;
    logic [PC_W-1:0] w_pc_plus2;
    logic            w_fen;
    logic            w_capture;
    logic            w_consume;
    logic            w_redir_ok;
    logic            w_redir_load;
    logic            w_redir_bad;
    logic [PC_W-1:0] w_redir_pc;

    // ERR is terminal: redirects are only honoured outside it.
    assign w_redir_ok = redirect_valid & (r_state != ST_ERR);

`ifdef ALIGN_CHECK_EN
    logic r_err;

    assign w_redir_bad  = w_redir_ok & redirect_pc[0];
    assign w_redir_load = w_redir_ok & ~redirect_pc[0];
    assign w_redir_pc   = redirect_pc;
    assign err          = r_err;
`else
    // Odd targets are silently rounded down to the even address.
    localparam logic [PC_W-1:0] LSB_CLR = {{(PC_W-1){1'b1}}, 1'b0};

    assign w_redir_bad  = 1'b0;
    assign w_redir_load = w_redir_ok;
    assign w_redir_pc   = redirect_pc & LSB_CLR;
    assign err          = 1'b0;
`endif

    assign w_fen = (r_state == ST_FETCH)
                 & (~r_valid | ~stall_in)
                 & ~redirect_valid;

    assign w_capture = w_fen & imem_ready;
    assign w_consume = r_valid & ~stall_in;

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_redir_load),
        .i_load_pc  (w_redir_pc),
        .i_inc      (w_capture),
        .o_pc       (w_pc),
        .o_pc_plus2 (w_pc_plus2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_instr    <= NOP_WORD;
            r_valid    <= 1'b0;
            r_pc_out   <= RESET_PC;
            r_pc_plus2 <= RESET_PC2;
            r_halted   <= 1'b0;
`ifdef ALIGN_CHECK_EN
            r_err      <= 1'b0;
`endif
        end else if (w_redir_bad) begin
            r_state  <= ST_ERR;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
`ifdef ALIGN_CHECK_EN
            r_err    <= 1'b1;
`endif
        end else if (w_redir_load) begin
            // Flush; a HALT still held is wrong-path.
            r_state  <= ST_FETCH;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else if (w_capture) begin
            r_instr    <= imem_rdata;
            r_pc_out   <= w_pc;
            r_pc_plus2 <= w_pc_plus2;
            r_valid    <= 1'b1;
            if (is_halt(imem_rdata)) begin
                r_state  <= ST_HALTED;
                r_halted <= 1'b1;
            end
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign imem_req     = w_fen & ~rst;
    assign imem_addr    = w_pc;
    assign instr_out    = r_instr;
    assign instr_valid  = r_valid;
    assign pc_out       = r_pc_out;
    assign pc_plus2_out = r_pc_plus2;
    assign halted       = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Memory is combinational; word i holds 16'h0800|i unless overridden.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        stall_in;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2_out;
    logic        halted;
    logic        err;

    logic [15:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[8'(imem_addr >> 1)];

    fetch_stage #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_in       (stall_in),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .pc_out         (pc_out),
        .pc_plus2_out   (pc_plus2_out),
        .halted         (halted),
        .err            (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two edges with default memory, release 1 unit after an edge.
    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        stall_in = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0800 | 16'(i);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        stall_in = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", instr_valid); end
        checks++; if (instr_out !== 16'h0800) begin errors++; $display("FAIL rst_instr: got %h exp 0800", instr_out); end
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL rst_pc_out: got %h exp 0000", pc_out); end
        checks++; if (pc_plus2_out !== 16'h0002) begin errors++; $display("FAIL rst_pc_plus2: got %h exp 0002", pc_plus2_out); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h exp 0000", imem_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b exp 0", halted); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
    endtask

    task automatic test_zero_wait();
        logic [15:0] exp_i [0:2];
        do_reset();
        mem[0] = 16'h4000;
        mem[1] = 16'h4800;
        mem[2] = 16'h0800;
        exp_i[0] = 16'h4000;
        exp_i[1] = 16'h4800;
        exp_i[2] = 16'h0800;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL zw_first_req: got req=%b addr=%h exp req=1 addr=0000", imem_req, imem_addr); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid%0d: got %b exp 1", k, instr_valid); end
            checks++; if (pc_out !== 16'(2 * k)) begin errors++; $display("FAIL zw_pc_out%0d: got %h exp %h", k, pc_out, 16'(2 * k)); end
            checks++; if (instr_out !== exp_i[k]) begin errors++; $display("FAIL zw_instr%0d: got %h exp %h", k, instr_out, exp_i[k]); end
            checks++; if (imem_addr !== 16'(2 * k + 2)) begin errors++; $display("FAIL zw_addr%0d: got %h exp %h", k, imem_addr, 16'(2 * k + 2)); end
            checks++; if (pc_plus2_out !== 16'(2 * k + 2)) begin errors++; $display("FAIL zw_plus2_%0d: got %h exp %h", k, pc_plus2_out, 16'(2 * k + 2)); end
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        imem_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin errors++; $display("FAIL wait_start: got req=%b addr=%h exp req=1 addr=0008", imem_req, imem_addr); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin errors++; $display("FAIL wait_hold%0d: got req=%b addr=%h exp req=1 addr=0008", k, imem_req, imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wait_valid%0d: got %b exp 0", k, instr_valid); end
        end
        imem_ready = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b1 || pc_out !== 16'h0008) begin errors++; $display("FAIL wait_capture: got valid=%b pc=%h exp valid=1 pc=0008", instr_valid, pc_out); end
        checks++; if (instr_out !== 16'h0804) begin errors++; $display("FAIL wait_instr: got %h exp 0804", instr_out); end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        stall_in = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b exp 0", imem_req); end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || pc_out !== 16'h0000 || instr_out !== 16'h0800) begin errors++; $display("FAIL stall_hold%0d: got v=%b pc=%h i=%h exp v=1 pc=0000 i=0800", k, instr_valid, pc_out, instr_out); end
            checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0002) begin errors++; $display("FAIL stall_req%0d: got req=%b addr=%h exp req=0 addr=0002", k, imem_req, imem_addr); end
        end
        stall_in = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_release_req: got %b exp 1", imem_req); end
        tick();
        checks++; if (instr_valid !== 1'b1 || pc_out !== 16'h0002 || instr_out !== 16'h0801) begin errors++; $display("FAIL stall_next: got v=%b pc=%h i=%h exp v=1 pc=0002 i=0801", instr_valid, pc_out, instr_out); end
    endtask

    task automatic test_halt();
        do_reset();
        mem[3] = 16'h0000;
        for (int k = 0; k < 4; k++) tick();
        checks++; if (instr_valid !== 1'b1 || pc_out !== 16'h0006 || instr_out !== 16'h0000) begin errors++; $display("FAIL halt_capture: got v=%b pc=%h i=%h exp v=1 pc=0006 i=0000", instr_valid, pc_out, instr_out); end
        checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_state: got halted=%b req=%b exp halted=1 req=0", halted, imem_req); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_drain: got %b exp 0", instr_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_stay%0d: got halted=%b req=%b exp halted=1 req=0", k, halted, imem_req); end
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_exit: got %b exp 0", halted); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020) begin errors++; $display("FAIL halt_redir_req: got req=%b addr=%h exp req=1 addr=0020", imem_req, imem_addr); end
        tick();
        checks++; if (instr_valid !== 1'b1 || pc_out !== 16'h0020 || instr_out !== 16'h0810) begin errors++; $display("FAIL halt_redir_fetch: got v=%b pc=%h i=%h exp v=1 pc=0020 i=0810", instr_valid, pc_out, instr_out); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h000a) begin errors++; $display("FAIL rw_wait: got req=%b addr=%h exp req=1 addr=000a", imem_req, imem_addr); end
        imem_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_req_drop: got %b exp 0", imem_req); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || pc_out !== 16'h0008) begin errors++; $display("FAIL rw_ignore_ready: got v=%b pc=%h exp v=0 pc=0008", instr_valid, pc_out); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL rw_target: got req=%b addr=%h exp req=1 addr=0040", imem_req, imem_addr); end
        tick();
        checks++; if (instr_valid !== 1'b1 || pc_out !== 16'h0040 || instr_out !== 16'h0820) begin errors++; $display("FAIL rw_fetch: got v=%b pc=%h i=%h exp v=1 pc=0040 i=0820", instr_valid, pc_out, instr_out); end
    endtask

    task automatic test_flush_valid();
        do_reset();
        tick();
        tick();
        stall_in = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0030;
        tick();
        stall_in = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", instr_valid); end
        checks++; if (imem_addr !== 16'h0030) begin errors++; $display("FAIL flush_addr: got %h exp 0030", imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 16'hfffe;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b1 || pc_out !== 16'hfffe || instr_out !== 16'h08ff) begin errors++; $display("FAIL wrap_capture: got v=%b pc=%h i=%h exp v=1 pc=fffe i=08ff", instr_valid, pc_out, instr_out); end
        checks++; if (pc_plus2_out !== 16'h0000 || imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next: got plus2=%h addr=%h exp plus2=0000 addr=0000", pc_plus2_out, imem_addr); end
    endtask

    task automatic test_align();
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0013;
        tick();
        redirect_valid = 1'b0;
        #1;
`ifdef ALIGN_CHECK_EN
        checks++; if (err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL align_err: got err=%b req=%b v=%b exp err=1 req=0 v=0", err, imem_req, instr_valid); end
        checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL align_pc_kept: got %h exp 0002", imem_addr); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++; if (err !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 16'h0002) begin errors++; $display("FAIL align_sticky: got err=%b req=%b addr=%h exp err=1 req=0 addr=0002", err, imem_req, imem_addr); end
`else
        checks++; if (err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0012) begin errors++; $display("FAIL align_round: got err=%b req=%b addr=%h exp err=0 req=1 addr=0012", err, imem_req, imem_addr); end
        tick();
        checks++; if (instr_valid !== 1'b1 || pc_out !== 16'h0012 || instr_out !== 16'h0809) begin errors++; $display("FAIL align_fetch: got v=%b pc=%h i=%h exp v=1 pc=0012 i=0809", instr_valid, pc_out, instr_out); end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        tick();
        tick();
        imem_ready = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL async_pre_req: got %b exp 1", imem_req); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_req: got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0 || pc_out !== 16'h0000 || imem_addr !== 16'h0000) begin errors++; $display("FAIL async_regs: got v=%b pc=%h addr=%h exp v=0 pc=0000 addr=0000", instr_valid, pc_out, imem_addr); end
        checks++; if (instr_out !== 16'h0800) begin errors++; $display("FAIL async_instr: got %h exp 0800", instr_out); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_mem_wait();
        test_stall();
        test_halt();
        test_redirect_wait();
        test_flush_valid();
        test_wrap();
        test_align();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the opcode decoder. Holds the program counter, issues requests to instruction memory over a ready handshake, and presents one instruction at a time in an output instruction register with a valid flag and its PC. Stops fetching on a fetched HALT opcode, and redirects on taken branches and jumps from the execute stage.

## Interface
- PC_W, 16, program counter and instruction-address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request; forced 0 while rst=1
- imem_addr  out  PC_W  fetch address, equal to the current PC
- imem_rdata  in  16  instruction word; valid when imem_ready=1
- imem_ready  in  1  memory returns imem_rdata this cycle
- redirect_valid  in  1  taken branch or jump; flush and load redirect_pc
- redirect_pc  in  PC_W  redirect target
- stall_in  in  1  downstream is not consuming the output register this cycle
- instr_out  out  16  held instruction; the decoder takes instr_out[15:11]
- instr_valid  out  1  instr_out is a live instruction
- pc_out  out  PC_W  address of instr_out
- pc_plus2_out  out  PC_W  pc_out+2 modulo 2^PC_W, used as link value and branch base
- halted  out  1  HALT fetched, fetching stopped
- err  out  1  misaligned redirect, sticky; tied 0 without ALIGN_CHECK_EN

## Operation
- States:
  - FETCH: normal fetching.
  - HALTED: a HALT has been fetched; no requests.
  - ERR: a misaligned redirect has occurred; no requests. This state exists only with ALIGN_CHECK_EN.
- Reset:
  - Outputs: pc=RESET_PC, instr_out=16'h0800 (NOP), instr_valid=0, pc_out=RESET_PC, halted=0, err=0.
  - State: FETCH.
- Fetch enable: `fen = (state==FETCH) & (!instr_valid | !stall_in) & !redirect_valid`.
  - imem_req = fen & !rst.
  - imem_addr = pc.
- Capture: on an edge with fen & imem_ready:
  - instr_out <= imem_rdata, pc_out <= pc, instr_valid <= 1, pc <= pc+2.
  - If imem_rdata[15:11]==5'b00000, state <= HALTED.
- Consume: on an edge with instr_valid & !stall_in and no capture, instr_valid <= 0.
- Memory wait: imem_req=1 with imem_ready=0 leaves pc and the output register unchanged. A stall_in rise while waiting drops imem_req; the memory accepts withdrawn requests.
- Redirect: highest priority, in every state except ERR.
  - instr_valid <= 0 (flush), pc <= redirect_pc, state <= FETCH.
  - Any in-flight request is dropped, and imem_ready in that cycle is ignored.
  - This also exits HALTED, because a HALT still in the output register is wrong-path.
- HALTED: instr_valid drains normally so the decoder still sees HALT. halted=1 and imem_req=0 until reset or redirect.
- Arithmetic: all PC arithmetic is modulo 2^PC_W. PC 16'hFFFE captures and wraps to 16'h0000.

## Timing
- Zero-wait memory (imem_ready same cycle as req): one instruction per cycle. instr_valid rises on the edge after the request cycle.
- N wait cycles: instr_valid rises N+1 edges after imem_req first rises.
- Redirect cycle: imem_req=0. The first request to the target is issued the following cycle.
- Capture and consume on the same edge: the new instruction replaces the old one with instr_valid held at 1, with no bubble.
- rst asserted mid-wait: imem_req drops to 0 immediately (asynchronous), and all registers return to their reset values.

## Configuration
- ALIGN_CHECK_EN defined:
  - redirect_valid with redirect_pc[0]=1 sets state <= ERR, err <= 1, instr_valid <= 0.
  - pc is unchanged.
  - ERR ignores redirects, and only rst exits it.
- ALIGN_CHECK_EN undefined: redirect_pc[0] is forced to 0 silently, and err is constant 0.

## Structure
- Shared package holds:
  - Opcode constants OP_HALT=5'b00000 and OP_NOP=5'b00001.
  - NOP_WORD=16'h0800.
  - The fetch state encoding (FETCH, HALTED, ERR).
- The decoder imports the same opcode constants.
- One sub-module, pc_reg: PC register with async reset to RESET_PC, a load port (redirect), an increment-by-2 enable, and outputs pc and pc+2.

## Test plan
- Reset release with zero-wait memory returning 16'h4000, 16'h4800, 16'h0800 → pc_out goes 0, 2, 4 on consecutive cycles, instr_valid stays 1, and imem_addr goes 0, 2, 4, 6.
- imem_ready held low 3 cycles at pc=8 → imem_addr stays 8 and imem_req stays 1; instr_valid rises on the 4th edge with pc_out=8.
- stall_in high 2 cycles while valid → instr_out and pc_out are held, imem_req=0, and the next PC is fetched the cycle after stall_in falls.
- Fetch 16'h0000 at pc=6 → instr_valid=1 with pc_out=6, then halted=1 and imem_req=0 indefinitely. A later redirect_pc=16'h0020 → halted=0 and the next imem_addr=16'h0020.
- redirect_valid during a memory wait at pc=10 with redirect_pc=16'h0040 → ready in that cycle is ignored, instr_valid=0, and the next imem_addr=16'h0040.
- With ALIGN_CHECK_EN, redirect_pc=16'h0013 → err=1, imem_req=0, and a following redirect_pc=16'h0020 has no effect. Without the macro, the same stimulus fetches from 16'h0012.
